servo_pwm_gen: RTL and testbench



---
 rtl/servo_pwm_gen.sv | 128 ++++++++++++
 tb/tb_servo_pwm_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen
//   Turns one 11-bit joystick axis value into a hobby-servo PWM pulse,
//   1..2 ms wide in a fixed frame. The axis value is clamped, snapped to
//   centre inside a deadzone, and scaled linearly. The commanded width is
//   latched only at frame boundaries, so a frame in progress is never
//   altered.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-low reset
//   en           output enable (gates pwm_out only; timebase keeps running)
//   pos_in[10:0] axis position, nominally 0..1023, from the SPI clock domain
//   pwm_out      servo PWM line
//   pulse_us     pulse width applied in the current frame, in us
//   frame_start  one-cycle strobe on the first clock of each frame
//
// Build option
//   SERVO_SLEW_LIMIT_EN : when defined, each frame update moves pulse_us
//   toward the target by at most SLEW_US. When undefined, pulse_us takes
//   the target directly and SLEW_US does not exist.

module servo_pwm_gen #(
  parameter int CLK_DIV  = 100,
  parameter int FRAME_US = 20000,
  parameter int MIN_US   = 1000,
  parameter int MAX_US   = 2000,
  parameter int DEADZONE = 20
`ifdef SERVO_SLEW_LIMIT_EN
  ,parameter int SLEW_US = 50
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [10:0] pos_in,
  output logic        pwm_out,
  output logic [11:0] pulse_us,
  output logic        frame_start
);

  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int UW = ($clog2(FRAME_US) > 12) ? $clog2(FRAME_US) : 12;
  localparam logic [11:0] CENTER_US = 12'((MIN_US + MAX_US) / 2);

  logic [10:0]   r_sync1;
  logic [10:0]   r_pos_s;
  logic [TW-1:0] r_tick;
  logic [UW-1:0] r_us;
  logic [11:0]   r_pulse;
  logic          r_pwm;
  logic          r_fs;

  logic          w_tick_wrap;
  logic          w_frame_end;
  logic [9:0]    w_p_clamp;
  logic [9:0]    w_p;
  logic [20:0]   w_prod;
  logic [10:0]   w_scaled;
  logic [11:0]   w_target_raw;
  logic [11:0]   w_target;
  logic [11:0]   w_next_pulse;

  assign w_tick_wrap = (r_tick == TW'(CLK_DIV - 1));
  assign w_frame_end = w_tick_wrap && (r_us == UW'(FRAME_US - 1));

  // Target pulse width from the synchronised position, combinational so the
  // frame-boundary register captures it with no extra latency.
  always_comb begin
    w_p_clamp = r_pos_s[10] ? 10'd1023 : r_pos_s[9:0];
    if ((w_p_clamp >= 10'(512 - DEADZONE)) && (w_p_clamp <= 10'(512 + DEADZONE)))
      w_p = 10'd512;
    else
      w_p = w_p_clamp;
    w_prod       = 21'(w_p) * 21'(MAX_US - MIN_US);
    w_scaled     = 11'(w_prod >> 10);
    w_target_raw = 12'(MIN_US) + {1'b0, w_scaled};
    w_target     = (w_target_raw > 12'(MAX_US)) ? 12'(MAX_US) : w_target_raw;
  end

`ifdef SERVO_SLEW_LIMIT_EN
  always_comb begin
    if (w_target > (r_pulse + 12'(SLEW_US)))
      w_next_pulse = r_pulse + 12'(SLEW_US);
    else if ((w_target + 12'(SLEW_US)) < r_pulse)
      w_next_pulse = r_pulse - 12'(SLEW_US);
    else
      w_next_pulse = w_target;
  end
`else
  assign w_next_pulse = w_target;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 11'd512;
      r_pos_s <= 11'd512;
      r_tick  <= '0;
      r_us    <= '0;
      r_pulse <= CENTER_US;
      r_pwm   <= 1'b0;
      r_fs    <= 1'b0;
    end else begin
      // pos_in comes from the divided SPI clock; two flops before use.
      r_sync1 <= pos_in;
      r_pos_s <= r_sync1;
      r_fs    <= w_frame_end;
      // Compare uses the pre-edge counter, so the high phase starts one
      // clock after frame_start and lasts exactly pulse_us microseconds.
      r_pwm   <= en && (r_us < UW'(r_pulse));
      if (w_tick_wrap) begin
        r_tick <= '0;
        if (w_frame_end) begin
          r_us    <= '0;
          r_pulse <= w_next_pulse;
        end else begin
          r_us <= r_us + UW'(1);
        end
      end else begin
        r_tick <= r_tick + TW'(1);
      end
    end
  end

  assign pwm_out     = r_pwm;
  assign pulse_us    = r_pulse;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_servo_pwm_gen.sv
module tb_servo_pwm_gen;

  localparam int CD   = 2;
  // Frame shortened to keep the run short; still longer than MAX_US.
  localparam int FUS  = 2050;
  localparam int FCLK = CD * FUS;
`ifdef SERVO_SLEW_LIMIT_EN
  localparam int SLEW = 50;
`else
  localparam int SLEW = 4096;
`endif
  localparam int NV = 11;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b1;
  logic [10:0] pos_in = 11'd512;
  logic        pwm_out;
  logic [11:0] pulse_us;
  logic        frame_start;

  always #5 clk = ~clk;

  servo_pwm_gen #(
    .CLK_DIV (CD),
    .FRAME_US(FUS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .pos_in     (pos_in),
    .pwm_out    (pwm_out),
    .pulse_us   (pulse_us),
    .frame_start(frame_start)
  );

  typedef struct { int pos; bit en; bit late; int tgt; } vec_t;
  typedef struct { int pulse; int high; } exp_t;

  vec_t vec [NV];
  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  int   exp_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int model(input int prev, input int tgt);
    if (tgt > prev + SLEW) return prev + SLEW;
    if (tgt < prev - SLEW) return prev - SLEW;
    return tgt;
  endfunction

  task automatic push(input int i);
    int   en_next;
    exp_t e;
    exp_prev = model(exp_prev, vec[i].tgt);
    en_next  = (i + 1 < NV) ? int'(vec[i+1].en) : 1;
    e.pulse  = exp_prev;
    e.high   = (en_next != 0) ? exp_prev * CD : 0;
    exp_q.push_back(e);
  endtask

  task automatic wait_fs(input string name);
    for (int n = 0; n < FCLK + 20; n++) begin
      @(negedge clk);
      if (frame_start) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: no frame_start within %0d clk", name, FCLK + 20);
  endtask

  // First frame after reset: no frame_start at its start, 1500 us high,
  // first strobe exactly one frame after release.
  task automatic measure_post_reset(input string tag);
    int n;
    int hi;
    bit seen;
    n = 0; hi = 0; seen = 0;
    while (!seen && n < FCLK + 20) begin
      @(negedge clk);
      n++;
      if (frame_start) seen = 1;
      else if (pwm_out) hi++;
    end
    chk({tag, "_first_fs_clk"}, seen ? n : -1, FCLK);
    chk({tag, "_first_high_clk"}, hi, 1500 * CD);
  endtask

  // Monitor: pops an expectation at every frame_start and checks the
  // latched width; closes the previous frame's high-time count.
  logic fs_prev = 1'b0;
  int   hi_cnt = 0;
  int   cur_high = 0;
  bit   mon_active = 0;

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      mon_active = 0;
      fs_prev    = 1'b0;
    end else begin
      if (frame_start) begin
        chk("fs_one_cycle", fs_prev, 0);
        if (mon_active) chk("high_clk", hi_cnt, cur_high);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("frame_pulse", pulse_us, e.pulse);
          cur_high   = e.high;
          hi_cnt     = 0;
          mon_active = 1;
        end else begin
          mon_active = 0;
        end
      end
      if (mon_active && pwm_out) hi_cnt++;
      fs_prev = frame_start;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // pos, en, late (change at us 700), hand-computed target
    vec[0]  = '{1023, 1'b1, 1'b0, 1999};
    vec[1]  = '{0,    1'b1, 1'b0, 1000};
    vec[2]  = '{530,  1'b1, 1'b0, 1500};
    vec[3]  = '{540,  1'b1, 1'b0, 1527};
    vec[4]  = '{1500, 1'b1, 1'b0, 1999};
    vec[5]  = '{512,  1'b1, 1'b0, 1500};
    vec[6]  = '{1023, 1'b1, 1'b1, 1999};
    vec[7]  = '{1023, 1'b0, 1'b0, 1999};
    vec[8]  = '{488,  1'b1, 1'b0, 1476};
    vec[9]  = '{492,  1'b1, 1'b0, 1500};
    vec[10] = '{533,  1'b1, 1'b0, 1520};
    exp_prev = 1500;

    repeat (10) @(negedge clk);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_pulse", pulse_us, 1500);
    chk("rst_fs", frame_start, 0);

    pos_in = 11'(vec[0].pos);
    rst    = 1'b1;
    push(0);
    measure_post_reset("boot");

    for (int i = 1; i < NV; i++) begin
      en = vec[i].en;
      if (vec[i].late) repeat (700 * CD) @(negedge clk);
      pos_in = 11'(vec[i].pos);
      push(i);
      wait_fs("vec_fs");
    end

    // Reset in the middle of a frame.
    repeat (1200 * CD) @(negedge clk);
    chk("pre_rst_pwm", pwm_out, (exp_prev >= 1200) ? 1 : 0);
    #1 rst = 1'b0;
    #1 chk("rst_async_pwm", pwm_out, 0);
    repeat (4) @(negedge clk);
    chk("rst2_pulse", pulse_us, 1500);
    chk("rst2_fs", frame_start, 0);
    exp_prev = 1500;
    rst = 1'b1;
    push(NV - 1);
    measure_post_reset("rst2");
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
